flk_conditioner: RTL and testbench
==================================

Name: flk_conditioner

Overview:
- Input conditioner for the raw flick button, upstream of the flasher FSM's `flk` input.
- Synchronises the asynchronous pin, debounces it with a 4-state FSM, and produces one held request per press.
- The request stays high until the slow (div_clk) domain acknowledges it via `sample_tick`, so no press is lost across the clock divider.
- Runs entirely on the fast FPGA clock.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000 — consecutive stable synced samples needed to accept a level change; minimum 2.
- REPEAT_CYCLES, 50_000_000 — autorepeat period while held; used only with the optional feature.
- CNT_W, $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1) — counter width; derived, do not override.

Ports:
- clk  input  1  FPGA clock; single clock domain.
- rst  input  1  Synchronous, active-low reset; sampled on the rising edge of clk.
- flk_raw  input  1  Asynchronous button pin, active-high.
- sample_tick  input  1  One-clk strobe marking the clk edge at which the div_clk consumer samples `flk`; acts as the acknowledge.
- flk  output  1  Held flick request to the flasher FSM.
- flk_level  output  1  Debounced button level.
- ovr  output  1  Sticky overrun flag: a press arrived while a request was still pending.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Synchroniser flops, counters, flk, flk_level and ovr all go to 0; state goes to IDLE.
  - Reset mid-count or mid-request discards everything.
- Synchroniser: two flops, reset to 0. `s` denotes the second flop's output.
- FSM states: IDLE (stable low), CHK_HIGH, PRESSED (stable high), CHK_LOW.
  - IDLE: if s==1, go to CHK_HIGH with cnt=1.
  - CHK_HIGH:
    - s==0: return to IDLE and clear cnt.
    - s==1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED.
    - Otherwise cnt++.
  - PRESSED: if s==0, go to CHK_LOW with cnt=1.
  - CHK_LOW: mirror of CHK_HIGH, returning to PRESSED or going to IDLE.
  - Any glitch shorter than DEBOUNCE_CYCLES synced samples produces no output change.
- flk_level is 1 exactly in PRESSED and CHK_LOW.
- Latency: if edge k is the first to sample flk_raw high and the pin is held, flk_level and flk go high after edge k+1+DEBOUNCE_CYCLES. Release is symmetric.
- Request handshake:
  - Set event = the CHK_HIGH→PRESSED transition.
  - On a set event, flk←1.
  - On an edge with sample_tick==1 and flk==1, flk←0.
  - Set event and sample_tick on the same edge: set wins, so flk stays 1 (the tick acknowledged the earlier request, and the new press stays pending). ovr is asserted in this case.
  - Set event while flk==1 and no tick: requests coalesce, flk stays 1, ovr←1.
  - sample_tick while flk==0 has no effect.
  - ovr clears only on reset.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Optional Feature:
- Macro FLK_AUTOREPEAT_EN.
- Defined:
  - While in PRESSED, a repeat counter increments each clk.
  - On reaching REPEAT_CYCLES-1 it generates a set event (same handshake/ovr rules) and restarts from 0.
  - The counter clears on leaving PRESSED. CHK_LOW holds it frozen, and a return to PRESSED resumes the count.
- Undefined:
  - Exactly one request per accepted press.
  - No repeat counter logic is synthesised; REPEAT_CYCLES is ignored.

Decomposition:
- Package flk_pkg:
  - typedef enum logic [1:0] flk_state_t {IDLE, CHK_HIGH, PRESSED, CHK_LOW}.
  - Default constants FLK_DEBOUNCE_DEFAULT and FLK_REPEAT_DEFAULT.
- Sub-module flk_sync: generic 2-flop synchroniser with synchronous active-low reset. It is reusable for rst pin conditioning later.
- The debounce FSM and the handshake stay in flk_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
- Reset: drive rst=0 for 3 edges with flk_raw=1 → flk, flk_level, ovr all 0; after release the press is accepted 5 edges later.
- Clean press: flk_raw 0→1 first sampled at edge k, sample_tick low → flk and flk_level go 1 after edge k+5; flk holds until tick.
- Glitch: flk_raw high for 3 edges then low → flk_level and flk remain 0 throughout; FSM back in IDLE.
- Acknowledge: flk=1, pulse sample_tick for one edge → flk=0 next cycle, ovr=0; a second tick with flk=0 has no effect.
- Overrun: press, release, press again before any tick → flk stays 1 and ovr=1; a later single tick clears flk, and ovr stays 1 until reset.
- Autorepeat (FLK_AUTOREPEAT_EN defined): hold the press, tick every 3 edges → a new request every 10 edges while held, none after release completes.

Source files
------------

// File: rtl/flk_pkg.sv
// Shared types and defaults for the flick-button conditioner.
package flk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHK_HIGH = 2'd1,
    PRESSED  = 2'd2,
    CHK_LOW  = 2'd3
  } flk_state_t;

  localparam int unsigned FLK_DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned FLK_REPEAT_DEFAULT   = 50_000_000;

  function automatic int unsigned flk_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flk_sync.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Synchronous active-low reset clears both stages; output lags input by two clk edges.
module flk_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/flk_conditioner.sv
// Flick button conditioner: sync, debounce FSM, held request acknowledged by sample_tick.
// Optional autorepeat while held is enabled by defining FLK_AUTOREPEAT_EN.
module flk_conditioner
  import flk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = FLK_DEBOUNCE_DEFAULT,
  parameter int unsigned REPEAT_CYCLES   = FLK_REPEAT_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(flk_max(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic flk_raw,
  input  logic sample_tick,
  output logic flk,
  output logic flk_level,
  output logic ovr
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  flk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flk_q, flk_d;
  logic             ovr_q, ovr_d;
  logic             press_acc;
  logic             set_evt;

  flk_sync u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (flk_raw),
    .q_o    (s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt only advances inside a CHK state and is cleared on every exit, so it never passes CNT_LAST
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = CHK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HIGH: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          press_acc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = CHK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LOW: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    flk_level = (state_q == PRESSED) || (state_q == CHK_LOW);
  end

`ifdef FLK_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             rpt_evt;

  // CHK_LOW freezes the count so a bounce back to PRESSED resumes the period
  always_comb begin
    rpt_d   = '0;
    rpt_evt = 1'b0;
    case (state_q)
      PRESSED: begin
        if (rpt_q == RPT_LAST) begin
          rpt_evt = 1'b1;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + CNT_ONE;
        end
      end
      CHK_LOW: rpt_d = rpt_q;
      default: rpt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end

  assign set_evt = press_acc | rpt_evt;
`else
  assign set_evt = press_acc;
`endif

  // A new request beats a same-edge acknowledge: the tick consumed the older one
  always_comb begin
    flk_d = flk_q;
    ovr_d = ovr_q;
    if (set_evt) begin
      flk_d = 1'b1;
      ovr_d = ovr_q | flk_q;
    end else if (sample_tick && flk_q) begin
      flk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flk_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      flk_q <= flk_d;
      ovr_q <= ovr_d;
    end
  end

  assign flk = flk_q;
  assign ovr = ovr_q;

endmodule

// File: tb/tb_flk_conditioner.sv
// Table-driven bench for flk_conditioner with a scoreboard of per-edge expected outputs.
module tb_flk_conditioner;

  localparam int DEB = 4;
  localparam int RPT = 10;

  logic clk         = 1'b0;
  logic rst         = 1'b0;
  logic flk_raw     = 1'b0;
  logic sample_tick = 1'b0;
  logic flk;
  logic flk_level;
  logic ovr;

  always #5 clk = ~clk;

  flk_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flk_raw     (flk_raw),
    .sample_tick (sample_tick),
    .flk         (flk),
    .flk_level   (flk_level),
    .ovr         (ovr)
  );

  // stim = {rst, flk_raw, sample_tick}; exp = {flk, flk_level, ovr} after the edge
  typedef struct {
    logic [2:0] stim;
    logic [2:0] exp;
    int         n;
  } vec_t;

  typedef struct {
    logic [2:0] exp;
    int         tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic [2:0] s, input logic [2:0] x, input int n);
    vec_t v;
    v.stim = s;
    v.exp  = x;
    v.n    = n;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [2:0] s, input logic [2:0] x, input int tag);
    exp_t e;
    @(negedge clk);
    {rst, flk_raw, sample_tick} = s;
    e.exp = x;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int tag, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b, expected %b", nm, tag, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("flk",       mon_e.tag, flk,       mon_e.exp[2]);
      chk("flk_level", mon_e.tag, flk_level, mon_e.exp[1]);
      chk("ovr",       mon_e.tag, ovr,       mon_e.exp[0]);
    end
  end

  initial begin
    // reset held with the pin high, then a press accepted 5 edges after release
    add(3'b010, 3'b000, 3);
    add(3'b110, 3'b000, 5);
    add(3'b110, 3'b110, 3);
    // acknowledge, then a second tick with flk low
    add(3'b111, 3'b010, 2);
    add(3'b110, 3'b010, 1);
    // release takes the same 5 edges
    add(3'b100, 3'b010, 5);
    add(3'b100, 3'b000, 2);
    // 3-sample glitch is rejected
    add(3'b110, 3'b000, 3);
    add(3'b100, 3'b000, 6);
    // clean press with no tick, release, second press before any tick
    add(3'b110, 3'b000, 5);
    add(3'b110, 3'b110, 1);
    add(3'b100, 3'b110, 5);
    add(3'b100, 3'b100, 1);
    add(3'b110, 3'b100, 5);
    add(3'b110, 3'b111, 1);
    add(3'b111, 3'b011, 1);
    add(3'b110, 3'b011, 1);
    // reset mid-press clears ovr; then set and tick on the same edge with flk high
    add(3'b000, 3'b000, 2);
    add(3'b110, 3'b000, 5);
    add(3'b110, 3'b110, 1);
    add(3'b100, 3'b110, 5);
    add(3'b100, 3'b100, 1);
    add(3'b110, 3'b100, 5);
    add(3'b111, 3'b111, 1);
    add(3'b111, 3'b011, 1);
    add(3'b110, 3'b011, 1);
    add(3'b100, 3'b011, 5);
    add(3'b100, 3'b001, 1);
    add(3'b000, 3'b000, 1);

    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        drive(tbl[r].stim, tbl[r].exp, r);
      end
    end

    // reset partway through a debounce count restarts it from scratch
    for (int k = 0; k < 3; k++) drive(3'b110, 3'b000, 1000 + k);
    drive(3'b010, 3'b000, 1003);
    for (int k = 0; k < 5; k++) drive(3'b110, 3'b000, 1004 + k);
    // set with a tick while flk is low: request taken, no overrun
    drive(3'b111, 3'b110, 1009);

`ifdef FLK_AUTOREPEAT_EN
    begin
      logic mf, mo, raw, tick, set, lvl;
      mf = 1'b1;
      mo = 1'b0;
      for (int i = 1; i <= 54; i++) begin
        raw  = (i <= 34);
        tick = (i % 3 == 0);
        set  = (i <= 34) && (i % RPT == 0);
        lvl  = (i < 40);
        if (set) begin
          mo = mo | mf;
          mf = 1'b1;
        end else if (tick) begin
          mf = 1'b0;
        end
        drive({1'b1, raw, tick}, {mf, lvl, mo}, 2000 + i);
      end
    end
`else
    drive(3'b111, 3'b010, 1010);
    // long hold yields no further request
    for (int k = 0; k < 20; k++) drive(3'b110, 3'b010, 1011 + k);
    for (int k = 0; k < 5; k++) drive(3'b100, 3'b010, 1031 + k);
    drive(3'b100, 3'b000, 1036);
`endif

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
